// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Ready/valid pipeline register carrying NUM_CH channels as one
//               entry. Define PIPE_SKID_REG_SKID_EN for the two-entry skid
//               variant, which removes the combinational out_ready->in_ready path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_CH    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          Flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH-1:0][WIDTH-1:0]  q,
  output logic [1:0]                    occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t                         state;
  state_t                         state_nx;
  logic                           load_main;
  logic [NUM_CH-1:0][WIDTH-1:0]   main_q;

`ifdef PIPE_SKID_REG_SKID_EN
  logic                           load_skid;
  logic                           pop_skid;
  logic [NUM_CH-1:0][WIDTH-1:0]   skid_q;
`endif

  // Next-state and register-load decode; Flush overrides every handshake.
  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
`ifdef PIPE_SKID_REG_SKID_EN
    load_skid = 1'b0;
    pop_skid  = 1'b0;
`endif
    if (Flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            load_main = 1'b1;
            state_nx  = FULL;
          end
        end
        FULL: begin
`ifdef PIPE_SKID_REG_SKID_EN
          if (in_valid && out_ready) begin
            load_main = 1'b1;
          end else if (in_valid) begin
            load_skid = 1'b1;
            state_nx  = SKID;
          end else if (out_ready) begin
            state_nx  = EMPTY;
          end
`else
          if (in_valid && out_ready) begin
            load_main = 1'b1;
          end else if (out_ready) begin
            state_nx  = EMPTY;
          end
`endif
        end
`ifdef PIPE_SKID_REG_SKID_EN
        SKID: begin
          if (out_ready) begin
            pop_skid = 1'b1;
            state_nx = FULL;
          end
        end
`endif
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= EMPTY;
      for (int i = 0; i < NUM_CH; i++) begin
        main_q[i] <= RESET_VAL;
      end
    end else begin
      state <= state_nx;
      if (load_main) begin
        main_q <= d;
      end
`ifdef PIPE_SKID_REG_SKID_EN
      else if (pop_skid) begin
        main_q <= skid_q;
      end
`endif
    end
  end

`ifdef PIPE_SKID_REG_SKID_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        skid_q[i] <= RESET_VAL;
      end
    end else if (load_skid) begin
      skid_q <= d;
    end
  end

  // Registered-only ready: depends on state, never on out_ready.
  assign in_ready = (state != SKID) && !Reset;
`else
  assign in_ready = (!out_valid || out_ready) && !Reset;
`endif

  assign out_valid = (state != EMPTY);
  assign q         = main_q;
  assign occupancy = (state == SKID) ? 2'd2 :
                     (state == FULL) ? 2'd1 : 2'd0;

endmodule

`default_nettype wire
